// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle instruction sequencer.
// Walks each instruction through FETCH, DECODE, REG_READ, EXECUTE, optional MEM
// and WRITEBACK. It owns the program counter and the retired-instruction count.
// FETCH and MEM each wait a bounded number of cycles for the memory acknowledge.
module cpu_sequencer #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          MEM_TIMEOUT = 8
) (
    input  logic        I_clk,
    input  logic        I_reset_n,
    input  logic        I_run,
    input  logic        I_mem_ready,
    input  logic        I_halt,
    input  logic        I_is_mem,
    input  logic        I_wb_en,
    input  logic        I_branch_taken,
    input  logic [15:0] I_branch_target,
    output logic [15:0] O_pc,
    output logic        O_fetch_req,
    output logic        O_dec_enable,
    output logic        O_reg_read_enable,
    output logic        O_alu_enable,
    output logic        O_mem_req,
    output logic        O_reg_write_enable,
    output logic        O_halted,
    output logic        O_fault,
    output logic [3:0]  O_state,
    output logic [15:0] O_retired
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_REG_READ  = 4'd3,
        ST_EXECUTE   = 4'd4,
        ST_MEM       = 4'd5,
        ST_WRITEBACK = 4'd6,
        ST_HALT      = 4'd7,
        ST_FAULT     = 4'd8
    } state_t;

    // The wait counter holds (cycles already spent waiting). While it equals
    // WAIT_LAST, the current cycle is the last one in which an acknowledge is accepted.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [7:0]  wait_cnt_reg, wait_cnt_next;
    logic [15:0] pc_reg, pc_next;
    logic [15:0] retired_reg;
    logic        timeout_hit;

    assign timeout_hit = (wait_cnt_reg == WAIT_LAST);

    // Register state, wait counter, PC and retired count. The reset is asynchronous.
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= 8'd0;
            pc_reg       <= RESET_PC;
            retired_reg  <= 16'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            pc_reg       <= pc_next;
            if (state_reg == ST_WRITEBACK) begin
                retired_reg <= retired_reg + 16'd1;
            end
        end
    end

    // Next-state logic. An acknowledge in the last allowed cycle beats the timeout.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (I_run) state_next = ST_FETCH;
            ST_FETCH: begin
                if (I_mem_ready)      state_next = ST_DECODE;
                else if (timeout_hit) state_next = ST_FAULT;
            end
            ST_DECODE:    state_next = I_halt ? ST_HALT : ST_REG_READ;
            ST_REG_READ:  state_next = ST_EXECUTE;
            ST_EXECUTE:   state_next = I_is_mem ? ST_MEM : ST_WRITEBACK;
            ST_MEM: begin
                if (I_mem_ready)      state_next = ST_WRITEBACK;
                else if (timeout_hit) state_next = ST_FAULT;
            end
            ST_WRITEBACK: state_next = I_run ? ST_FETCH : ST_IDLE;
            ST_HALT:      state_next = ST_HALT;
            ST_FAULT:     state_next = ST_FAULT;
            default:      state_next = ST_IDLE;
        endcase
    end

    // Wait counter: clear on any state change, otherwise count unacknowledged waits.
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (state_next != state_reg) begin
            wait_cnt_next = 8'd0;
        end else if (((state_reg == ST_FETCH) || (state_reg == ST_MEM)) && !I_mem_ready) begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
        end
    end

    // PC changes only when an instruction retires: branch target or sequential.
    always_comb begin
        pc_next = pc_reg;
        if (state_reg == ST_WRITEBACK) begin
            pc_next = I_branch_taken ? I_branch_target : pc_reg + 16'd1;
        end
    end

    // Moore decode of stage enables and terminal status from the current state.
    always_comb begin
        O_fetch_req       = 1'b0;
        O_dec_enable      = 1'b0;
        O_reg_read_enable = 1'b0;
        O_alu_enable      = 1'b0;
        O_mem_req         = 1'b0;
        O_halted          = 1'b0;
        O_fault           = 1'b0;
        case (state_reg)
            ST_FETCH:    O_fetch_req       = 1'b1;
            ST_DECODE:   O_dec_enable      = 1'b1;
            ST_REG_READ: O_reg_read_enable = 1'b1;
            ST_EXECUTE:  O_alu_enable      = 1'b1;
            ST_MEM:      O_mem_req         = 1'b1;
            ST_HALT:     O_halted          = 1'b1;
            ST_FAULT:    O_fault           = 1'b1;
            default:     ;
        endcase
    end

    // The register-file write follows the decoder flag during WRITEBACK only.
    assign O_reg_write_enable = (state_reg == ST_WRITEBACK) && I_wb_en;

    assign O_state   = state_reg;
    assign O_pc      = pc_reg;
    assign O_retired = retired_reg;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: randomized instruction-level checking of cpu_sequencer.
// Each instruction has a fetch latency, an optional memory latency, and
// branch/writeback flags. The expected state trace is built from these values.
// The PC and retired-count model is updated once per retired instruction.
module tb_cpu_sequencer;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam int          TMO    = 8;

    logic        I_clk;
    logic        I_reset_n;
    logic        I_run;
    logic        I_mem_ready;
    logic        I_halt;
    logic        I_is_mem;
    logic        I_wb_en;
    logic        I_branch_taken;
    logic [15:0] I_branch_target;
    logic [15:0] O_pc;
    logic        O_fetch_req;
    logic        O_dec_enable;
    logic        O_reg_read_enable;
    logic        O_alu_enable;
    logic        O_mem_req;
    logic        O_reg_write_enable;
    logic        O_halted;
    logic        O_fault;
    logic [3:0]  O_state;
    logic [15:0] O_retired;

    cpu_sequencer #(.RESET_PC(RST_PC), .MEM_TIMEOUT(TMO)) dut (
        .I_clk              (I_clk),
        .I_reset_n          (I_reset_n),
        .I_run              (I_run),
        .I_mem_ready        (I_mem_ready),
        .I_halt             (I_halt),
        .I_is_mem           (I_is_mem),
        .I_wb_en            (I_wb_en),
        .I_branch_taken     (I_branch_taken),
        .I_branch_target    (I_branch_target),
        .O_pc               (O_pc),
        .O_fetch_req        (O_fetch_req),
        .O_dec_enable       (O_dec_enable),
        .O_reg_read_enable  (O_reg_read_enable),
        .O_alu_enable       (O_alu_enable),
        .O_mem_req          (O_mem_req),
        .O_reg_write_enable (O_reg_write_enable),
        .O_halted           (O_halted),
        .O_fault            (O_fault),
        .O_state            (O_state),
        .O_retired          (O_retired)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] m_pc;
    logic [15:0] m_retired;
    int          m_term;   // 0 = running, 7 = halted, 8 = faulted

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected {fetch, dec, reg_read, alu, mem, halted, fault} for each numbered state.
    function automatic logic [6:0] stage_outs(input int st);
        case (st)
            1:       return 7'b1000000;
            2:       return 7'b0100000;
            3:       return 7'b0010000;
            4:       return 7'b0001000;
            5:       return 7'b0000100;
            7:       return 7'b0000010;
            8:       return 7'b0000001;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic chk_state(input int st);
        #1;
        check_value($sformatf("state(exp %0d)", st), O_state, st);
        check_value($sformatf("outs(st %0d)", st),
                    {O_fetch_req, O_dec_enable, O_reg_read_enable, O_alu_enable,
                     O_mem_req, O_halted, O_fault}, stage_outs(st));
        check_value($sformatf("wr_en(st %0d)", st), O_reg_write_enable, (st == 6) && I_wb_en);
        check_value($sformatf("pc(st %0d)", st), O_pc, m_pc);
        check_value($sformatf("retired(st %0d)", st), O_retired, m_retired);
    endtask

    task automatic step();
        @(posedge I_clk);
        @(negedge I_clk);
    endtask

    // Randomize every input; callers then fix the ones that matter in the current stage.
    task automatic noise();
        I_run           = 1'($urandom);
        I_mem_ready     = 1'($urandom);
        I_halt          = 1'($urandom);
        I_is_mem        = 1'($urandom);
        I_wb_en         = 1'($urandom);
        I_branch_taken  = 1'($urandom);
        I_branch_target = 16'($urandom);
    endtask

    // Sit in IDLE for n cycles with run low, then raise run. The next cycle is FETCH.
    task automatic go_idle(input int n);
        for (int k = 0; k < n; k++) begin
            noise(); I_run = 1'b0; chk_state(0); step();
        end
        noise(); I_run = 1'b1; chk_state(0); step();
    endtask

    // Wait for memory: an acknowledge arrives after lat waits, or never if lat >= TMO.
    task automatic wait_mem(input int st, input int lat, output bit faulted);
        faulted = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            noise(); I_mem_ready = (i == lat); chk_state(st); step();
            if (i == lat) return;
        end
        faulted = 1'b1;
    endtask

    // One instruction, starting in FETCH.
    task automatic do_instr(input int fw, input bit is_mem, input int mw, input bit halt,
                            input bit br, input logic [15:0] tgt, input bit wb, input bit run_after);
        bit f;
        m_term = 0;
        wait_mem(1, fw, f);
        if (f) begin m_term = 8; return; end
        noise(); I_halt = halt; chk_state(2); step();
        if (halt) begin m_term = 7; return; end
        noise(); chk_state(3); step();
        noise(); I_is_mem = is_mem; chk_state(4); step();
        if (is_mem) begin
            wait_mem(5, mw, f);
            if (f) begin m_term = 8; return; end
        end
        noise(); I_wb_en = wb; I_run = run_after; I_branch_taken = br; I_branch_target = tgt;
        chk_state(6); step();
        m_pc      = br ? tgt : m_pc + 16'd1;
        m_retired = m_retired + 16'd1;
    endtask

    // Hold in a terminal state while run stays high and the other inputs toggle.
    task automatic hold_check(input int st, input int n);
        for (int k = 0; k < n; k++) begin
            noise(); I_run = 1'b1; chk_state(st); step();
        end
    endtask

    // Assert reset away from any clock edge and check that it takes effect immediately.
    task automatic apply_reset();
        #2;
        I_reset_n = 1'b0;
        m_pc      = RST_PC;
        m_retired = 16'd0;
        chk_state(0);
        @(negedge I_clk);
        for (int k = 0; k < 2; k++) begin
            noise(); I_mem_ready = 1'b1; I_run = 1'b1; chk_state(0); step();
        end
        I_reset_n = 1'b1;
    endtask

    initial begin
        bit ra;
        I_reset_n = 1'b0;
        I_run = 1'b0; I_mem_ready = 1'b0; I_halt = 1'b0; I_is_mem = 1'b0;
        I_wb_en = 1'b0; I_branch_taken = 1'b0; I_branch_target = 16'h0;
        m_pc = RST_PC; m_retired = 16'd0; m_term = 0;
        repeat (2) @(negedge I_clk);
        chk_state(0);
        I_reset_n = 1'b1;
        go_idle(3);

        // Directed cases: plain instruction, delayed MEM, last-cycle fetch acknowledge, branches and PC wrap.
        do_instr(0, 1'b0, 0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        do_instr(0, 1'b1, 3, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        do_instr(TMO - 1, 1'b0, 0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        do_instr(0, 1'b1, TMO - 1, 1'b0, 1'b1, 16'h0040, 1'b1, 1'b1);
        do_instr(2, 1'b0, 0, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1);
        do_instr(0, 1'b0, 0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        go_idle(2);

        // Random instructions; none of them exceeds the timeout.
        for (int n = 0; n < 40; n++) begin
            ra = 1'($urandom);
            do_instr($urandom_range(0, TMO - 1), 1'($urandom), $urandom_range(0, TMO - 1), 1'b0,
                     ($urandom_range(0, 3) == 0), 16'($urandom), 1'($urandom), ra);
            if (!ra) go_idle($urandom_range(0, 3));
        end

        // Take an instruction into MEM, then reset in the middle of the memory wait.
        noise(); I_mem_ready = 1'b1; chk_state(1); step();
        noise(); I_halt = 1'b0; chk_state(2); step();
        noise(); chk_state(3); step();
        noise(); I_is_mem = 1'b1; chk_state(4); step();
        noise(); I_mem_ready = 1'b0; chk_state(5); step();
        noise(); I_mem_ready = 1'b0; chk_state(5);
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            noise(); I_run = 1'b0; I_mem_ready = 1'b1; chk_state(0); step();
        end
        go_idle(0);

        // Halt in DECODE, then hold it for 20 cycles with run high.
        do_instr(1, 1'b0, 0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
        hold_check(7, 20);
        apply_reset();
        go_idle(1);

        // Fetch that is never acknowledged: FAULT after TMO cycles, PC unchanged.
        do_instr(0, 1'b0, 0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        do_instr(TMO, 1'b0, 0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        hold_check(8, 5);
        apply_reset();
        go_idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-003 Parameter MEM_TIMEOUT, default 8, legal range 1..255: maximum wait cycles for I_mem_ready in FETCH or MEM.
REQ-004 I_clk  in  1  clock; all state updates occur on the rising edge.
REQ-005 I_reset_n  in  1  asynchronous active-low reset.
REQ-006 I_run  in  1  start/continue execution.
REQ-007 I_mem_ready  in  1  memory acknowledge for the current fetch or data access.
REQ-008 I_halt  in  1  decoder flag: the current instruction is HALT.
REQ-009 I_is_mem  in  1  decoder flag: the current instruction is a load or store.
REQ-010 I_wb_en  in  1  decoder flag: the current instruction writes the register file.
REQ-011 I_branch_taken  in  1  the current instruction is a taken branch.
REQ-012 I_branch_target  in  16  branch destination PC.
REQ-013 O_pc  out  16  current instruction address.
REQ-014 O_fetch_req, O_dec_enable, O_reg_read_enable, O_alu_enable, O_mem_req, O_reg_write_enable  out  1 each  stage enables.
REQ-015 O_halted, O_fault  out  1 each  terminal status.
REQ-016 O_state  out  4  state encoding: IDLE=0, FETCH=1, DECODE=2, REG_READ=3, EXECUTE=4, MEM=5, WRITEBACK=6, HALT=7, FAULT=8.
REQ-017 O_retired  out  16  count of completed WRITEBACK cycles.

Function
REQ-018 The state SHALL be registered, and every enable and status output SHALL be a Moore decode of the state, except O_reg_write_enable.
REQ-019 IDLE: all enables SHALL be 0; the next state SHALL be FETCH if I_run=1, otherwise IDLE.
REQ-020 FETCH: O_fetch_req SHALL be 1; the next state SHALL be DECODE on I_mem_ready=1, otherwise FETCH or FAULT according to the timeout rule.
REQ-021 DECODE: O_dec_enable SHALL be 1 for exactly one cycle; the next state SHALL be HALT if I_halt=1, otherwise REG_READ.
REQ-022 REG_READ: O_reg_read_enable SHALL be 1 for one cycle; the next state SHALL be EXECUTE.
REQ-023 EXECUTE: O_alu_enable SHALL be 1 for one cycle; the next state SHALL be MEM if I_is_mem=1, otherwise WRITEBACK.
REQ-024 MEM: O_mem_req SHALL be 1; the next state SHALL be WRITEBACK on I_mem_ready=1, otherwise MEM or FAULT according to the timeout rule.
REQ-025 WRITEBACK: O_reg_write_enable SHALL equal I_wb_en for one cycle.
REQ-026 WRITEBACK: O_retired SHALL increment by 1, wrapping 16'hFFFF to 0.
REQ-027 WRITEBACK: the next state SHALL be FETCH if I_run=1, otherwise IDLE.
REQ-028 On the WRITEBACK edge, O_pc SHALL load I_branch_target if I_branch_taken=1, otherwise O_pc+1, wrapping 16'hFFFF to 16'h0000.
REQ-029 O_pc SHALL NOT change in any state other than WRITEBACK.
REQ-030 Timeout: a wait counter SHALL clear on entry to FETCH or MEM and increment on each cycle spent in that state with I_mem_ready=0.
REQ-031 Timeout: if I_mem_ready=0 in the MEM_TIMEOUT-th cycle of a FETCH or MEM state, the next state SHALL be FAULT.
REQ-032 I_mem_ready=1 in the final allowed cycle SHALL take priority over the timeout.
REQ-033 HALT: O_halted SHALL be 1; the state SHALL be held until reset, regardless of I_run.
REQ-034 FAULT: O_fault SHALL be 1 and all enables SHALL be 0; the state SHALL be held until reset.
REQ-035 I_run deasserting mid-instruction SHALL NOT abort the instruction; it SHALL take effect only at WRITEBACK.
REQ-036 Exactly one stage enable SHALL be 1 in each of FETCH, DECODE, REG_READ, EXECUTE and MEM.

Reset
REQ-037 Reset assertion SHALL immediately, without a clock edge, force: state=IDLE, O_pc=RESET_PC, O_retired=0, wait counter=0, all outputs 0.
REQ-038 Reset assertion mid-handshake SHALL abandon the access, and the block SHALL NOT complete it after reset release.
REQ-039 After reset release, the block SHALL remain in IDLE until I_run is sampled high.

Verification
REQ-040 Scenario: run=1, mem_ready=1 always, no mem, wb_en=1 -> state sequence 1,2,3,4,6,1; O_pc 0->1; O_retired=1 after 5 cycles.
REQ-041 Scenario: I_is_mem=1, mem_ready delayed 3 cycles in MEM -> O_mem_req high for 4 cycles, then WRITEBACK.
REQ-042 Scenario: mem_ready never asserted in FETCH, MEM_TIMEOUT=8 -> FAULT after 8 FETCH cycles; O_fault=1; O_pc unchanged.
REQ-043 Scenario: mem_ready first asserted in the 8th FETCH cycle -> DECODE, no fault.
REQ-044 Scenario: branch_taken=1, target=16'h0040 at WRITEBACK -> O_pc=16'h0040; O_pc=16'hFFFF with no branch -> 16'h0000.
REQ-045 Scenario: I_halt=1 in DECODE -> HALT with O_halted=1, held for 20 cycles with run=1; reset_n low mid-MEM -> immediate IDLE, pc=RESET_PC.
